clock_time_bcd: RTL and testbench

Time-of-day counter producing the six BCD digits (hh:mm:ss) consumed by the seven-segment scan/display block. It divides the 1 kHz system clock to a 1 Hz tick, keeps 24-hour time with BCD carries, and has a two-button set interface (mode/increment) with on-chip synchronisers and debouncers. It sits between the board buttons and the display multiplexer, on the same clock.

---
 rtl/clock_time_bcd.sv | 193 +++++++++++++++++++
 tb/tb_clock_time_bcd.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_bcd.sv
`timescale 1ns/1ps
// clock_time_bcd: 24-hour BCD time-of-day counter with a 1 Hz prescaler and a
// two-button (mode / increment) set interface with synchronisers and debouncers.

// One button: 2-flop synchroniser, then a debouncer that produces a single-cycle
// press pulse on an accepted low->high change of level.
module clock_time_bcd_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_1khz,
  input  logic rstn,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ;

  assign differ = sync_q[1] ^ level_q;
  // The edge that flips the level to high is the press itself, so the action
  // lands on the same edge the accepted level changes.
  assign press  = differ && sync_q[1] && (cnt_q == CNT_LAST);

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    if (differ) begin
      if (cnt_q == CNT_LAST) level_d = sync_q[1];
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // Synchroniser, accepted level and debounce counter.
  always_ff @(posedge clk_1khz or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module clock_time_bcd #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int DEBOUNCE_MS   = 20
) (
  input  logic       clk_1khz,
  input  logic       rstn,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hour0,
  output logic [3:0] hour1,
  output logic [1:0] mode,
  output logic       sec_pulse
);
  localparam int NUM_BTN = 2;
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  mode_e               state_q, state_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [7:0]          sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic                sec_pulse_q, sec_pulse_d;
  logic [NUM_BTN-1:0]  btn_raw, btn_press;
  logic                mode_press, inc_press;
  logic                run_en, hour_step, min_step, leave_set_min, tick;
  logic [8:0]          sec_inc, min_inc, hour_inc;

  // {carry, tens, units} for a 00..59 BCD field.
  function automatic logic [8:0] inc_base60(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     return {1'b1, 8'h00};
  endfunction

  // {wrap, tens, units} for a 00..23 BCD hour field.
  function automatic logic [8:0] inc_hours(input logic [7:0] v);
    if (v == 8'h23)          return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign btn_raw    = {btn_inc, btn_mode};
  assign mode_press = btn_press[0];
  assign inc_press  = btn_press[1];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    clock_time_bcd_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk_1khz (clk_1khz),
      .rstn     (rstn),
      .btn_raw  (btn_raw[i]),
      .press    (btn_press[i])
    );
  end

  // Mode state register.
  always_ff @(posedge clk_1khz or negedge rstn) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Mode sequence RUN -> SET_HOUR -> SET_MIN -> RUN on each mode press.
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Per-mode control strobes; a mode press always wins over an increment.
  always_comb begin
    run_en        = (state_q == RUN);
    hour_step     = (state_q == SET_HOUR) && inc_press && !mode_press;
    min_step      = (state_q == SET_MIN)  && inc_press && !mode_press;
    leave_set_min = (state_q == SET_MIN)  && mode_press;
  end

  assign tick     = run_en && (pre_q == PRE_MAX);
  assign sec_inc  = inc_base60(sec_q);
  assign min_inc  = inc_base60(min_q);
  assign hour_inc = inc_hours(hour_q);

  // Prescaler, tick-driven carry chain and set-mode digit edits.
  always_comb begin
    pre_d       = pre_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    sec_pulse_d = tick;
    if (run_en) pre_d = tick ? '0 : pre_q + 1'b1;
    if (tick) begin
      sec_d = sec_inc[7:0];
      if (sec_inc[8]) begin
        min_d = min_inc[7:0];
        if (min_inc[8]) hour_d = hour_inc[7:0];
      end
    end
    if (hour_step) hour_d = hour_inc[7:0];
    if (min_step)  min_d  = min_inc[7:0];
    // Returning to RUN restarts the second from a clean boundary.
    if (leave_set_min) begin
      sec_d = '0;
      pre_d = '0;
    end
  end

  // Time, prescaler and pulse registers.
  always_ff @(posedge clk_1khz or negedge rstn) begin
    if (!rstn) begin
      pre_q       <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  assign {sec1, sec0}   = sec_q;
  assign {min1, min0}   = min_q;
  assign {hour1, hour0} = hour_q;
  assign mode           = state_q;
  assign sec_pulse      = sec_pulse_q;
endmodule

// File: tb/tb_clock_time_bcd.sv
`timescale 1ns/1ps
// Self-checking bench for clock_time_bcd with a seconds-of-day reference model.
module tb_clock_time_bcd;
  localparam int T = 4;
  localparam int D = 3;

  logic       clk_1khz = 1'b0;
  logic       rstn = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
  logic [1:0] mode;
  logic       sec_pulse;

  clock_time_bcd #(.TICKS_PER_SEC(T), .DEBOUNCE_MS(D)) dut (
    .clk_1khz (clk_1khz),
    .rstn     (rstn),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec0     (sec0),
    .sec1     (sec1),
    .min0     (min0),
    .min1     (min1),
    .hour0    (hour0),
    .hour1    (hour1),
    .mode     (mode),
    .sec_pulse(sec_pulse)
  );

  always #5 clk_1khz = ~clk_1khz;

  wire [23:0] dig = {hour1, hour0, min1, min0, sec1, sec0};

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time as seconds since midnight, mode 0/1/2, prescaler count.
  int m_t, m_mode, m_pre, cyc;
  bit m_pulse;

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_pre = 0; m_pulse = 0; cyc = 0;
  endtask

  // Advance one rising edge; mp/ip say whether a debounced press lands on it.
  task automatic step(input bit mp, input bit ip);
    bit tk;
    @(posedge clk_1khz); #1;
    tk = (m_mode == 0) && (m_pre == T - 1);
    m_pulse = tk;
    if (m_mode == 0) m_pre = (m_pre + 1) % T;
    if (tk) m_t = (m_t + 1) % 86400;
    if (mp) begin
      if (m_mode == 2) begin m_t = m_t - m_t % 60; m_pre = 0; end
      m_mode = (m_mode + 1) % 3;
    end else if (ip) begin
      if (m_mode == 1)      m_t = ((m_t / 3600 + 1) % 24) * 3600 + m_t % 3600;
      else if (m_mode == 2) m_t = (m_t / 3600) * 3600 + (((m_t / 60) % 60 + 1) % 60) * 60 + m_t % 60;
    end
    cyc++;
  endtask

  // Clean press: held until accepted (D+2 edges), then released until the level drops.
  task automatic press(input bit do_mode, input bit do_inc);
    btn_mode = do_mode; btn_inc = do_inc;
    for (int i = 1; i <= D + 2; i++) step(do_mode && i == D + 2, do_inc && i == D + 2);
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (D + 3) step(1'b0, 1'b0);
  endtask

  task automatic set_time(input int h, input int m);
    int n;
    press(1'b1, 1'b0);
    n = (h - m_t / 3600 + 24) % 24;
    repeat (n) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    n = (m - (m_t / 60) % 60 + 60) % 60;
    repeat (n) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_1khz); rstn = 1'b0;
    @(negedge clk_1khz); rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0; #1;
    n_chk++;
    if (dig !== 24'h0 || mode !== 2'b00 || sec_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset_async: dig=%h mode=%b pulse=%b want 000000/00/0", dig, mode, sec_pulse);
    end
    repeat (2) @(posedge clk_1khz); #1;
    n_chk++;
    if (dig !== 24'h0 || mode !== 2'b00 || sec_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: dig=%h mode=%b pulse=%b want 000000/00/0", dig, mode, sec_pulse);
    end
    @(negedge clk_1khz); rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_run();
    int npulse = 0, last = 0;
    for (int i = 0; i < 240; i++) begin
      step(1'b0, 1'b0);
      n_chk++;
      if (sec_pulse !== m_pulse) begin
        n_err++; $display("FAIL run_pulse: cyc %0d got %b want %b", cyc, sec_pulse, m_pulse);
      end
      if (sec_pulse) begin
        npulse++;
        n_chk++;
        if (cyc - last != T) begin
          n_err++; $display("FAIL run_spacing: got %0d want %0d", cyc - last, T);
        end
        last = cyc;
      end
    end
    n_chk++;
    if (npulse != 60) begin n_err++; $display("FAIL run_count: got %0d want 60", npulse); end
    n_chk++;
    if (dig !== 24'h000100 || dig !== to_bcd(m_t)) begin
      n_err++; $display("FAIL run_digits: got %h want 000100", dig);
    end
  endtask

  task automatic test_wrap();
    int hrs[3] = '{23, 9, 19};
    logic [23:0] after[3] = '{24'h000000, 24'h100000, 24'h200000};
    int tgt, n;
    for (int k = 0; k < 3; k++) begin
      set_time(hrs[k], 59);
      tgt = hrs[k] * 3600 + 3599;
      n = 0;
      while (m_t != tgt && n < 400) begin
        step(1'b0, 1'b0); n++;
        n_chk++;
        if (sec_pulse !== m_pulse) begin
          n_err++; $display("FAIL wrap_pulse: got %b want %b", sec_pulse, m_pulse);
        end
      end
      n_chk++;
      if (n >= 400 || dig !== to_bcd(tgt)) begin
        n_err++; $display("FAIL wrap_preload: got %h want %h", dig, to_bcd(tgt));
      end
      for (int i = 1; i <= T; i++) begin
        step(1'b0, 1'b0);
        n_chk++;
        if (sec_pulse !== (i == T)) begin
          n_err++; $display("FAIL wrap_tick_pulse: edge %0d got %b want %b", i, sec_pulse, (i == T));
        end
      end
      n_chk++;
      if (dig !== after[k] || dig !== to_bcd(m_t)) begin
        n_err++; $display("FAIL wrap_rollover: got %h want %h", dig, after[k]);
      end
    end
  endtask

  task automatic test_set();
    do_reset();
    press(1'b1, 1'b0);
    n_chk++;
    if (mode !== 2'b01) begin n_err++; $display("FAIL set_enter_hour: got %b want 01", mode); end
    repeat (25) press(1'b0, 1'b1);
    n_chk++;
    if (dig[23:16] !== 8'h01 || dig !== to_bcd(m_t)) begin
      n_err++; $display("FAIL set_hours: got %h want hours 01 (%h)", dig, to_bcd(m_t));
    end
    press(1'b1, 1'b0);
    n_chk++;
    if (mode !== 2'b10) begin n_err++; $display("FAIL set_enter_min: got %b want 10", mode); end
    repeat (61) press(1'b0, 1'b1);
    n_chk++;
    if (dig[23:8] !== 16'h0101 || dig !== to_bcd(m_t)) begin
      n_err++; $display("FAIL set_minutes: got %h want 0101xx (%h)", dig, to_bcd(m_t));
    end
    btn_mode = 1'b1;
    for (int i = 1; i <= D + 2; i++) step(i == D + 2, 1'b0);
    btn_mode = 1'b0;
    n_chk++;
    if (mode !== 2'b00 || dig !== 24'h010100) begin
      n_err++; $display("FAIL set_leave: mode=%b dig=%h want 00/010100", mode, dig);
    end
    for (int i = 1; i <= T; i++) begin
      step(1'b0, 1'b0);
      n_chk++;
      if (sec_pulse !== (i == T)) begin
        n_err++; $display("FAIL set_first_pulse: edge %0d got %b want %b", i, sec_pulse, (i == T));
      end
    end
    repeat (D) step(1'b0, 1'b0);
  endtask

  task automatic test_simul();
    logic [23:0] e;
    press(1'b1, 1'b0);
    e = to_bcd(m_t);
    press(1'b1, 1'b1);
    n_chk++;
    if (mode !== 2'b10 || dig[23:16] !== e[23:16] || dig !== to_bcd(m_t)) begin
      n_err++; $display("FAIL simul_mode_wins: mode=%b dig=%h want 10/%h", mode, dig, e);
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_bounce();
    logic [23:0] e0, e1;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    e0 = to_bcd(m_t);
    e1 = to_bcd((m_t / 3600) * 3600 + (((m_t / 60) % 60 + 1) % 60) * 60 + m_t % 60);
    btn_inc = 1'b1; step(1'b0, 1'b0); step(1'b0, 1'b0);
    btn_inc = 1'b0; step(1'b0, 1'b0);
    btn_inc = 1'b1;
    for (int i = 4; i <= 65; i++) begin
      step(1'b0, i == 8);
      if (i == 7) begin
        n_chk++;
        if (dig !== e0) begin n_err++; $display("FAIL bounce_early: got %h want %h", dig, e0); end
      end
      if (i == 8) begin
        n_chk++;
        if (dig !== e1) begin n_err++; $display("FAIL bounce_accept: got %h want %h", dig, e1); end
      end
    end
    n_chk++;
    if (dig !== e1 || dig !== to_bcd(m_t)) begin
      n_err++; $display("FAIL bounce_no_repeat: got %h want %h", dig, e1);
    end
    btn_inc = 1'b0;
    repeat (D + 3) step(1'b0, 1'b0);
    press(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int tgt, n;
    set_time(12, 34);
    tgt = 12 * 3600 + 34 * 60 + 55;
    n = 0;
    while (m_t != tgt && n < 400) begin step(1'b0, 1'b0); n++; end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    n_chk++;
    if (n >= 400 || mode !== 2'b10 || dig !== 24'h123456) begin
      n_err++; $display("FAIL rmid_setup: mode=%b dig=%h want 10/123456", mode, dig);
    end
    btn_mode = 1'b1;
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    #2 rstn = 1'b0; #1;
    n_chk++;
    if (dig !== 24'h0 || mode !== 2'b00 || sec_pulse !== 1'b0) begin
      n_err++; $display("FAIL rmid_reset: dig=%h mode=%b pulse=%b want 000000/00/0", dig, mode, sec_pulse);
    end
    @(negedge clk_1khz); rstn = 1'b1;
    model_reset();
    for (int i = 1; i <= D + 2; i++) begin
      step(i == D + 2, 1'b0);
      if (i >= D + 1) begin
        n_chk++;
        if (mode !== 2'(m_mode)) begin
          n_err++; $display("FAIL rmid_held_press: edge %0d got %b want %0d", i, mode, m_mode);
        end
      end
    end
    n_chk++;
    if (mode !== 2'b01 || dig !== to_bcd(m_t)) begin
      n_err++; $display("FAIL rmid_after: mode=%b dig=%h want 01/%h", mode, dig, to_bcd(m_t));
    end
    btn_mode = 1'b0;
    repeat (D + 3) step(1'b0, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
  endtask

  task automatic test_random();
    int h, m, n;
    logic [23:0] e;
    for (int k = 0; k < 3; k++) begin
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      n = $urandom_range(20, 300);
      set_time(h, m);
      e = to_bcd(h * 3600 + m * 60);
      n_chk++;
      if (dig[23:8] !== e[23:8] || dig !== to_bcd(m_t) || mode !== 2'b00) begin
        n_err++; $display("FAIL rand_set: got %h mode=%b want %h", dig, mode, to_bcd(m_t));
      end
      repeat (n) begin
        step(1'b0, 1'b0);
        n_chk++;
        if (sec_pulse !== m_pulse) begin
          n_err++; $display("FAIL rand_pulse: got %b want %b", sec_pulse, m_pulse);
        end
      end
      n_chk++;
      if (dig !== to_bcd(m_t)) begin
        n_err++; $display("FAIL rand_run: got %h want %h", dig, to_bcd(m_t));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_wrap();
    test_set();
    test_simul();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
